// File: rtl/arbitro_registro.sv
// arbitro_registro: two-requester arbiter guarding one shared N-bit register.
// Ties go to the requester that was not most recently released, and a grant
// ends early on done, on a dropped request, or after MAXHOLD cycles.
module arbitro_registro #(
   parameter int N       = 8,
   parameter int MAXHOLD = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [1:0]   req,
   input  logic [1:0]   done,
   input  logic [N-1:0] d0,
   input  logic [N-1:0] d1,
   output logic [1:0]   grant,
   output logic         we,
   output logic [N-1:0] q,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_e;

   // Hold counter reaching this value means the current cycle is the last one
   // the grant may occupy.
   localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

   state_e         state_q, state_d;
   logic           last_q, last_d;
   logic [7:0]     hold_q, hold_d;
   logic [N-1:0]   q_q;
   logic           own;     // index of the granted requester
   logic           rel;     // current grant ends at this edge

   // Grant and busy are pure decodes of the state register.
   assign grant = {state_q == G1, state_q == G0};
   assign busy  = (state_q != IDLE);
   // Write enable follows the live request of the owner; forced low in reset.
   assign we    = reset_n & ((grant[0] & req[0]) | (grant[1] & req[1]));
   assign q     = q_q;

   // Next-state, priority pointer and hold counter.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      own     = (state_q == G1);
      rel     = 1'b0;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (req == 2'b01)      state_d = G0;
            else if (req == 2'b10) state_d = G1;
            else if (req == 2'b11) state_d = last_q ? G0 : G1;
         end
         G0, G1: begin
            // The other requester's done is ignored while not granted.
            rel = done[own] | ~req[own] | (hold_q == HOLD_LAST);
            if (rel) begin
               last_d = own;
               hold_d = '0;
               if (req[~own]) state_d = own ? G0 : G1;
               else           state_d = IDLE;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // State, pointer, counter and shared register; reset beats any write.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         hold_q  <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         if (we) q_q <= grant[1] ? d1 : d0;
      end
   end

endmodule

// File: doc/arbitro_registro.md
ARBITRO_REGISTRO -- requirements
Module: arbitro_registro

Interface
REQ-001 Parameter N, default 8: width of the shared register and of each data input.
REQ-002 Parameter MAXHOLD, default 4: maximum number of consecutive cycles a single grant may last; legal range 1..255.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed). The ports are clock and reset_n.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 req  input  2  req[k]=1: requester k wants to write the shared register.
REQ-007 done  input  2  done[k]=1: requester k releases the grant this cycle.
REQ-008 d0  input  N  write data from requester 0.
REQ-009 d1  input  N  write data from requester 1.
REQ-010 grant  output  2  one-hot grant, or 00; registered.
REQ-011 we  output  1  write enable of the shared register; combinational (Mealy).
REQ-012 q  output  N  shared register contents; registered.
REQ-013 busy  output  1  1 whenever grant != 00.

Function
REQ-014 States: IDLE, G0, G1; grant=00 in IDLE, 01 in G0, 10 in G1; at most one grant bit is ever set.
REQ-015 Priority pointer last (1 bit) holds the index of the most recently released requester.
REQ-016 IDLE, req=00: stay in IDLE.
REQ-017 IDLE, exactly one req[k]=1: next state Gk; grant latency from request to grant is exactly 1 cycle.
REQ-018 IDLE, req=11: next state G(~last), so ties alternate between requesters.
REQ-019 Hold counter: cleared on every entry into G0 or G1; increments each cycle spent in that state.
REQ-020 Release condition in Gk: done[k]=1, or req[k]=0, or hold counter = MAXHOLD-1 (timeout).
REQ-021 On release from Gk: last <= k.
REQ-022 On release from Gk with req[~k]=1: next state G(~k), with no IDLE cycle between the two grants.
REQ-023 On release from Gk with req[~k]=0: next state IDLE, even if req[k] is still 1; requester k is re-granted one cycle later through REQ-017.
REQ-024 Without release, Gk stays in Gk; inputs req[~k] and done[~k] are ignored while in Gk.
REQ-025 we = grant[k] & req[k] for the granted k.
REQ-026 we depends on the current-cycle req, so it is a Mealy output.
REQ-027 A write still occurs in the cycle in which done[k]=1.
REQ-028 When we=1, q <= dk on the rising edge; otherwise q holds its value.
REQ-029 done[k] with grant[k]=0 has no effect.
REQ-030 A grant never exceeds MAXHOLD consecutive cycles.
REQ-031 With MAXHOLD=1, every grant lasts exactly one cycle.

Reset
REQ-032 reset_n=0 at a rising edge forces: state IDLE, grant=00, busy=0, q=0, hold counter=0, last=1. Requester 0 therefore wins the first tie.
REQ-033 Reset has priority over every other event, including an active grant or write; we=0 while reset_n=0.
REQ-034 After reset_n returns to 1, a request pending in the first cycle is granted after the normal 1-cycle latency.

Verification (N=8, MAXHOLD=4)
REQ-035 Reset scenario: hold reset_n=0 for 2 edges with req=11 and d0=FF -> grant=00, q=00, busy=0, we=0 throughout.
REQ-036 Single requester scenario:
- req=01, d0=5A; done0=1 on the 2nd granted cycle.
- grant=01 one cycle after req rises, we=1 for 2 cycles, q=5A.
- grant=00 on the cycle after done.
REQ-037 Tie and hand-over scenario:
- req=11 from reset, d0=11, d1=22; done0 on the 1st granted cycle.
- grant sequence 00, 01, 10 with no gap; q=11, then 22.
- Repeat the tie after IDLE -> grant=01.
REQ-038 Timeout scenario: req=10 held, done=00 -> grant=10 for exactly 4 cycles, 00 for 1 cycle, then 10 again; busy follows grant.
REQ-039 Request-drop scenario: in G0, drop req0 with no done and with req1=1 -> we=0 in that cycle, grant=10 next cycle, q unchanged by requester 0.
REQ-040 Mid-grant reset scenario: in G1 on its 2nd cycle, reset_n=0 for one edge -> grant=00, q=00. Next, req=11 -> grant=01 (last=1 restored).
